// File: rtl/lc3b_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Shared type definitions for the LC-3b memory subsystem.
//            Holds the Wishbone arbiter FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

  // Arbiter FSM states, explicitly one bit wide.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_arb_state_t;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/wb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Scans the request vector
//            starting at last+1 (modulo NUM_CH) and returns the first
//            requesting channel.
// Ports    : req   in  NUM_CH  request vector, one bit per channel
//            last  in  IDX_W   most recently served channel
//            valid out 1       at least one request present
//            idx   out IDX_W   selected channel (0 when valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [IDX_W:0] C_NUM_CH = (IDX_W + 1)'(NUM_CH);

  // One extra bit so last+k (at most 2*NUM_CH-1) never overflows before
  // the modulo fold.
  logic [IDX_W:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest requester
  // (highest priority) is the last assignment and wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_cand = {1'b0, last} + (IDX_W + 1)'(k);
      if (w_cand >= C_NUM_CH) begin
        w_cand = w_cand - C_NUM_CH;
      end
      if (req[w_cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : N-channel Wishbone arbiter. Merges NUM_CH upstream master ports
//            onto one shared slave port with round-robin fairness, steers the
//            slave ack to the granted channel only, and keeps per-channel
//            saturating grant / wait-cycle counters.
// Ports    : clk, rst_n                  clock, async active-low reset
//            s_cyc/s_stb/s_we[N]         upstream request strobes
//            s_adr/s_dat_m/s_sel[N]      upstream request fields
//            s_dat_s[N], s_ack[N]        response to upstream
//            m_cyc..m_sel                request to shared slave
//            m_dat_s, m_ack              response from shared slave
//            grant_cnt[N], wait_cnt[N]   performance counters
//            grant_clr[N], wait_clr[N]   synchronous counter clears
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  s_cyc     [NUM_CH],
  input  logic                  s_stb     [NUM_CH],
  input  logic                  s_we      [NUM_CH],
  input  logic [ADDR_W-1:0]     s_adr     [NUM_CH],
  input  logic [DATA_W-1:0]     s_dat_m   [NUM_CH],
  input  logic [DATA_W/8-1:0]   s_sel     [NUM_CH],
  output logic [DATA_W-1:0]     s_dat_s   [NUM_CH],
  output logic                  s_ack     [NUM_CH],

  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_adr,
  output logic [DATA_W-1:0]     m_dat_m,
  output logic [DATA_W/8-1:0]   m_sel,
  input  logic [DATA_W-1:0]     m_dat_s,
  input  logic                  m_ack,

  output logic [CNT_W-1:0]      grant_cnt [NUM_CH],
  output logic [CNT_W-1:0]      wait_cnt  [NUM_CH],
  input  logic                  grant_clr [NUM_CH],
  input  logic                  wait_clr  [NUM_CH]
);

  localparam int               IDX_W      = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  wb_arb_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_gnt,   w_gnt_nxt;
  logic [IDX_W-1:0]  r_last,  w_last_nxt;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant_inc;
  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req    (w_req),
    .last   (r_last),
    .valid  (w_pick_valid),
    .idx    (w_pick_idx)
  );

  // --------------------------------------------------------------------------
  // State register. Reset is asynchronous so m_cyc (decoded from r_state)
  // drops immediately when rst_n falls mid-transaction.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= C_LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_grant_inc = '0;
    m_cyc       = 1'b0;
    m_stb       = 1'b0;
    m_we        = 1'b0;
    m_adr       = '0;
    m_dat_m     = '0;
    m_sel       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_ack[i] = 1'b0;
    end

    case (r_state)
      IDLE: begin
        // m_ack seen here is a stale/late response and is dropped.
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick_idx;
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        m_cyc   = s_cyc[r_gnt];
        m_stb   = s_stb[r_gnt];
        m_we    = s_we[r_gnt];
        m_adr   = s_adr[r_gnt];
        m_dat_m = s_dat_m[r_gnt];
        m_sel   = s_sel[r_gnt];

        if (m_ack) begin
          s_ack[r_gnt]       = 1'b1;
          w_grant_inc[r_gnt] = 1'b1;
          w_last_nxt         = r_gnt;
          w_state_nxt        = IDLE;
        end else if (!s_cyc[r_gnt]) begin
          // Abort: no ack and no count, but the channel still moves to the
          // back of the round-robin order.
          w_last_nxt  = r_gnt;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-channel request decode, read-data fan-out and saturating counters.
  // A clear takes priority over a coincident increment.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_grant_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_wait_inc;

    assign w_req[gi]   = s_cyc[gi] & s_stb[gi];
    assign s_dat_s[gi] = m_dat_s;

    // A channel is waiting whenever it requests but does not own the bus.
    assign w_wait_inc = w_req[gi] & ~((r_state == BUSY) && (r_gnt == IDX_W'(gi)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_grant_cnt <= '0;
      end else if (grant_clr[gi]) begin
        r_grant_cnt <= '0;
      end else if (w_grant_inc[gi] && (r_grant_cnt != '1)) begin
        r_grant_cnt <= r_grant_cnt + C_CNT_ONE;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wait_cnt <= '0;
      end else if (wait_clr[gi]) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + C_CNT_ONE;
      end
    end

    assign grant_cnt[gi] = r_grant_cnt;
    assign wait_cnt[gi]  = r_wait_cnt;
  end : g_ch

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter (4 channels, 10-bit counters
//            so saturation is reachable in a short run). Directed scenarios
//            plus a randomized run against a transaction-level reference
//            model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int NCH  = 4;
  localparam int AW   = 12;
  localparam int DW   = 128;
  localparam int SW   = DW / 8;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          s_cyc     [NCH];
  logic          s_stb     [NCH];
  logic          s_we      [NCH];
  logic [AW-1:0] s_adr     [NCH];
  logic [DW-1:0] s_dat_m   [NCH];
  logic [SW-1:0] s_sel     [NCH];
  logic [DW-1:0] s_dat_s   [NCH];
  logic          s_ack     [NCH];
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_m;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_dat_s;
  logic          m_ack;
  logic [CW-1:0] grant_cnt [NCH];
  logic [CW-1:0] wait_cnt  [NCH];
  logic          grant_clr [NCH];
  logic          wait_clr  [NCH];

  logic [NCH-1:0] ack_vec;
  assign ack_vec = {s_ack[3], s_ack[2], s_ack[1], s_ack[0]};

  int total = 0;
  int bad   = 0;

  wb_arbiter #(
    .NUM_CH (NCH),
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_m   (s_dat_m),
    .s_sel     (s_sel),
    .s_dat_s   (s_dat_s),
    .s_ack     (s_ack),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_dat_m   (m_dat_m),
    .m_sel     (m_sel),
    .m_dat_s   (m_dat_s),
    .m_ack     (m_ack),
    .grant_cnt (grant_cnt),
    .wait_cnt  (wait_cnt),
    .grant_clr (grant_clr),
    .wait_clr  (wait_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic clear_inputs();
    for (int i = 0; i < NCH; i++) begin
      s_cyc[i] = 1'b0; s_stb[i] = 1'b0; s_we[i] = 1'b0;
      s_adr[i] = '0;   s_dat_m[i] = '0; s_sel[i] = '0;
      grant_clr[i] = 1'b0; wait_clr[i] = 1'b0;
    end
    m_dat_s = '0;
    m_ack   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic req(input int ch, input logic [AW-1:0] adr);
    s_cyc[ch] = 1'b1; s_stb[ch] = 1'b1; s_adr[ch] = adr;
    s_we[ch] = ch[0]; s_sel[ch] = SW'(16'hF0F0 ^ ch);
    s_dat_m[ch] = {4{32'hA5A5_0000 | ch}};
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      s_cyc[i] = 1'b1; s_stb[i] = 1'b1; s_we[i] = 1'b1;
      s_adr[i] = AW'(i + 1); s_dat_m[i] = '1; s_sel[i] = '1;
      grant_clr[i] = 1'b0; wait_clr[i] = 1'b0;
    end
    m_ack = 1'b1; m_dat_s = '0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      total++;
      if ({m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel} !== '0) begin
        bad++; $display("FAIL reset_m_outputs: got cyc=%0b adr=%0h want all zero", m_cyc, m_adr);
      end
      total++;
      if (ack_vec !== 4'b0000) begin
        bad++; $display("FAIL reset_s_ack: got %b want 0000", ack_vec);
      end
      for (int i = 0; i < NCH; i++) begin
        total++;
        if (grant_cnt[i] !== '0 || wait_cnt[i] !== '0 || s_dat_s[i] !== '0) begin
          bad++; $display("FAIL reset_counters ch%0d: got g=%0d w=%0d want 0", i, grant_cnt[i], wait_cnt[i]);
        end
      end
    end
    tick();
    rst_n = 1'b1;
    clear_inputs();
    req(0, 12'h100);
    req(1, 12'h200);
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b0) begin
      bad++; $display("FAIL reset_first_idle: got m_cyc=%b want 0", m_cyc);
    end
    tick();
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b1 || m_adr !== 12'h100) begin
      bad++; $display("FAIL reset_ch0_first: got cyc=%b adr=%0h want 1/100", m_cyc, m_adr);
    end
    m_ack = 1'b1;
    #1;
    total++;
    if (ack_vec !== 4'b0001) begin
      bad++; $display("FAIL reset_ack0: got %b want 0001", ack_vec);
    end
    tick();
    m_ack = 1'b0;
    s_cyc[0] = 1'b0; s_stb[0] = 1'b0;
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b0 || grant_cnt[0] !== CW'(1) || wait_cnt[0] !== CW'(1) || wait_cnt[1] !== CW'(2)) begin
      bad++; $display("FAIL reset_counts: got cyc=%b g0=%0d w0=%0d w1=%0d want 0/1/1/2",
                      m_cyc, grant_cnt[0], wait_cnt[0], wait_cnt[1]);
    end
    tick();
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b1 || m_adr !== 12'h200) begin
      bad++; $display("FAIL reset_ch1_next: got cyc=%b adr=%0h want 1/200", m_cyc, m_adr);
    end
  endtask

  task automatic test_fairness();
    int exp_ch;
    apply_reset();
    for (int i = 0; i < NCH; i++) req(i, AW'(12'h010 * (i + 1)));
    for (int t = 0; t < 8; t++) begin
      exp_ch = t % NCH;
      @(negedge clk);
      total++;
      if (m_cyc !== 1'b0) begin
        bad++; $display("FAIL fair_idle t%0d: got m_cyc=%b want 0", t, m_cyc);
      end
      tick();
      for (int b = 0; b < 3; b++) begin
        if (b == 2) m_ack = 1'b1;
        @(negedge clk);
        if (b == 0) begin
          total++;
          if (m_cyc !== 1'b1 || m_adr !== AW'(12'h010 * (exp_ch + 1))) begin
            bad++; $display("FAIL fair_order t%0d: got adr=%0h want %0h", t, m_adr, 12'h010 * (exp_ch + 1));
          end
        end
        if (b == 2) begin
          total++;
          if (ack_vec !== (4'b0001 << exp_ch)) begin
            bad++; $display("FAIL fair_ack t%0d: got %b want %b", t, ack_vec, 4'b0001 << exp_ch);
          end
        end
        tick();
      end
      m_ack = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (grant_cnt[i] !== CW'(2) || wait_cnt[i] !== CW'(26)) begin
        bad++; $display("FAIL fair_counts ch%0d: got g=%0d w=%0d want 2/26", i, grant_cnt[i], wait_cnt[i]);
      end
    end
  endtask

  task automatic test_ack_steer();
    logic [DW-1:0] d;
    d = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    apply_reset();
    req(1, 12'h321);
    tick();
    m_dat_s = d;
    m_ack   = 1'b1;
    @(negedge clk);
    total++;
    if (ack_vec !== 4'b0010) begin
      bad++; $display("FAIL steer_ack: got %b want 0010", ack_vec);
    end
    total++;
    if (s_dat_s[0] !== d || s_dat_s[1] !== d || s_dat_s[3] !== d) begin
      bad++; $display("FAIL steer_data: got %0h want %0h", s_dat_s[0], d);
    end
    total++;
    if (grant_cnt[1] !== '0) begin
      bad++; $display("FAIL steer_cnt_before: got %0d want 0", grant_cnt[1]);
    end
    tick();
    m_ack = 1'b0;
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0;
    @(negedge clk);
    total++;
    if (grant_cnt[1] !== CW'(1) || grant_cnt[0] !== '0 || m_cyc !== 1'b0) begin
      bad++; $display("FAIL steer_cnt_after: got g1=%0d g0=%0d cyc=%b want 1/0/0", grant_cnt[1], grant_cnt[0], m_cyc);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    req(0, 12'h0A0);
    req(1, 12'h0B1);
    tick();
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b1 || m_adr !== 12'h0A0) begin
      bad++; $display("FAIL abort_grant0: got cyc=%b adr=%0h want 1/0a0", m_cyc, m_adr);
    end
    tick();
    s_cyc[0] = 1'b0;
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b0 || ack_vec !== 4'b0000) begin
      bad++; $display("FAIL abort_drop: got cyc=%b ack=%b want 0/0000", m_cyc, ack_vec);
    end
    tick();
    s_cyc[0] = 1'b1;
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b0 || grant_cnt[0] !== '0) begin
      bad++; $display("FAIL abort_idle: got cyc=%b g0=%0d want 0/0", m_cyc, grant_cnt[0]);
    end
    tick();
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b1 || m_adr !== 12'h0B1) begin
      bad++; $display("FAIL abort_next: got cyc=%b adr=%0h want 1/0b1", m_cyc, m_adr);
    end
  endtask

  task automatic test_sat_clear();
    apply_reset();
    req(0, 12'h011);
    req(1, 12'h022);
    repeat (1100) tick();
    @(negedge clk);
    total++;
    if (wait_cnt[1] !== CW'(CMAX) || wait_cnt[0] !== CW'(1) || grant_cnt[0] !== '0) begin
      bad++; $display("FAIL sat_reach: got w1=%0d w0=%0d g0=%0d want %0d/1/0", wait_cnt[1], wait_cnt[0], grant_cnt[0], CMAX);
    end
    repeat (5) tick();
    @(negedge clk);
    total++;
    if (wait_cnt[1] !== CW'(CMAX)) begin
      bad++; $display("FAIL sat_hold: got %0d want %0d", wait_cnt[1], CMAX);
    end
    tick();
    wait_clr[1] = 1'b1;
    tick();
    wait_clr[1] = 1'b0;
    @(negedge clk);
    total++;
    if (wait_cnt[1] !== '0) begin
      bad++; $display("FAIL clr_from_sat: got %0d want 0", wait_cnt[1]);
    end
    tick();
    @(negedge clk);
    total++;
    if (wait_cnt[1] !== CW'(1)) begin
      bad++; $display("FAIL clr_resume: got %0d want 1", wait_cnt[1]);
    end
    tick();
    wait_clr[1] = 1'b1;
    tick();
    wait_clr[1] = 1'b0;
    @(negedge clk);
    total++;
    if (wait_cnt[1] !== '0) begin
      bad++; $display("FAIL clr_beats_inc: got %0d want 0", wait_cnt[1]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req(2, 12'h222);
    tick();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b1 || m_adr !== 12'h222) begin
      bad++; $display("FAIL rmid_busy: got cyc=%b adr=%0h want 1/222", m_cyc, m_adr);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_cyc !== 1'b0 || grant_cnt[2] !== '0) begin
      bad++; $display("FAIL rmid_async_drop: got cyc=%b g2=%0d want 0/0", m_cyc, grant_cnt[2]);
    end
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    req(3, 12'h333);
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b0) begin
      bad++; $display("FAIL rmid_idle: got cyc=%b want 0", m_cyc);
    end
    tick();
    @(negedge clk);
    total++;
    if (m_cyc !== 1'b1 || m_adr !== 12'h222) begin
      bad++; $display("FAIL rmid_rearb: got cyc=%b adr=%0h want 1/222", m_cyc, m_adr);
    end
  endtask

  // Randomized run: masters issue/abort requests at random, the slave acks
  // after a random latency, clears fire occasionally. The reference model
  // tracks bus ownership and counter values per the arbitration rules.
  task automatic test_random();
    bit            busy;
    int            owner, last, lat, bcyc, pick;
    bit            act [NCH];
    bit            acked [NCH];
    int            gcnt [NCH];
    int            wcnt [NCH];
    bit            rq, busy_before;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [NCH-1:0] e_ack;

    apply_reset();
    busy = 0; owner = 0; last = NCH - 1; lat = 0; bcyc = 0;
    for (int i = 0; i < NCH; i++) begin
      act[i] = 0; acked[i] = 0; gcnt[i] = 0; wcnt[i] = 0;
    end

    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (acked[i]) begin
          act[i] = 0;
        end else if (!act[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[i]     = 1;
            s_adr[i]   = AW'($urandom);
            s_dat_m[i] = {$urandom, $urandom, $urandom, $urandom};
            s_sel[i]   = SW'($urandom);
            s_we[i]    = 1'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          act[i] = 0;
        end
        s_cyc[i]     = act[i];
        s_stb[i]     = act[i];
        grant_clr[i] = ($urandom_range(0, 49) == 0);
        wait_clr[i]  = ($urandom_range(0, 49) == 0);
      end
      m_dat_s = {$urandom, $urandom, $urandom, $urandom};
      if (busy) m_ack = (bcyc >= lat);
      else      m_ack = ($urandom_range(0, 9) == 0);

      // Expected outputs for this cycle.
      e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0; e_ack = '0;
      if (busy) begin
        e_cyc = s_cyc[owner]; e_stb = s_stb[owner]; e_we = s_we[owner];
        e_adr = s_adr[owner]; e_dat = s_dat_m[owner]; e_sel = s_sel[owner];
        if (m_ack) e_ack[owner] = 1'b1;
      end

      @(negedge clk);
      total++;
      if ({m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel} !== {e_cyc, e_stb, e_we, e_adr, e_dat, e_sel}) begin
        bad++; $display("FAIL rnd_m_bus c%0d: got cyc=%b adr=%0h want cyc=%b adr=%0h", cyc, m_cyc, m_adr, e_cyc, e_adr);
      end
      total++;
      if (ack_vec !== e_ack) begin
        bad++; $display("FAIL rnd_ack c%0d: got %b want %b", cyc, ack_vec, e_ack);
      end
      total++;
      if (s_dat_s[0] !== m_dat_s || s_dat_s[NCH-1] !== m_dat_s) begin
        bad++; $display("FAIL rnd_dat_s c%0d: got %0h want %0h", cyc, s_dat_s[0], m_dat_s);
      end
      for (int i = 0; i < NCH; i++) begin
        total++;
        if (grant_cnt[i] !== CW'(gcnt[i]) || wait_cnt[i] !== CW'(wcnt[i])) begin
          bad++; $display("FAIL rnd_cnt c%0d ch%0d: got g=%0d w=%0d want g=%0d w=%0d",
                          cyc, i, grant_cnt[i], wait_cnt[i], gcnt[i], wcnt[i]);
        end
      end

      @(posedge clk);
      busy_before = busy;
      for (int i = 0; i < NCH; i++) begin
        rq = s_cyc[i] && s_stb[i];
        acked[i] = 0;
        if (grant_clr[i]) gcnt[i] = 0;
        else if (busy_before && owner == i && m_ack && gcnt[i] < CMAX) gcnt[i]++;
        if (wait_clr[i]) wcnt[i] = 0;
        else if (rq && !(busy_before && owner == i) && wcnt[i] < CMAX) wcnt[i]++;
      end
      if (!busy) begin
        pick = -1;
        for (int k = 1; k <= NCH; k++) begin
          if (pick < 0 && s_cyc[(last + k) % NCH] && s_stb[(last + k) % NCH]) pick = (last + k) % NCH;
        end
        if (pick >= 0) begin
          busy = 1; owner = pick; bcyc = 0; lat = $urandom_range(0, 3);
        end
      end else if (m_ack) begin
        acked[owner] = 1; last = owner; busy = 0;
      end else if (!s_cyc[owner]) begin
        last = owner; busy = 0;
      end else begin
        bcyc++;
      end
      #1;
    end
    m_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_fairness();
    test_ack_steer();
    test_abort();
    test_sat_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_arbiter
`default_nettype wire
